// File: rtl/route_check_arbiter_if.sv
// Request/response bundle between requesters and the route checker.
// master: requester side (drives req_valid/req_route/rsp_ready).
// slave: arbiter side (drives req_ready and the rsp_* result).
interface route_check_arbiter_if #(
   parameter int N_REQ = 4
);
   localparam int RID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ*14-1:0] req_route;
   logic [N_REQ-1:0]    req_ready;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [RID_W-1:0]    rsp_req_id;
   logic                rsp_pass;
   logic [3:0]          rsp_dest;

   modport master (
      output req_valid, req_route, rsp_ready,
      input  req_ready, rsp_valid, rsp_req_id, rsp_pass, rsp_dest
   );

   modport slave (
      input  req_valid, req_route, rsp_ready,
      output req_ready, rsp_valid, rsp_req_id, rsp_pass, rsp_dest
   );
endinterface

// File: rtl/route_check_arbiter.sv
// Round-robin arbiter in front of a shared route capability checker.
// Ports: aclk/areset, cfg_* entry writes, rbus (req/rsp), viol_cnt, busy.
module route_check_arbiter #(
   parameter int N_REQ   = 4,
   parameter int N_DESTS = 4,
   parameter int CNT_W   = 16,
   localparam int RID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int IDX_W  = (N_DESTS > 1) ? $clog2(N_DESTS) : 1
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   cfg_we,
   input  logic [IDX_W-1:0]       cfg_idx,
   input  logic [13:0]            cfg_route_ctrl,
   route_check_arbiter_if.slave   rbus,
   output logic [CNT_W-1:0]       viol_cnt,
   output logic                   busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_RESP
   } state_t;

   state_t             state_q, state_d;
   logic [RID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [7:0]         route_q, route_d;
   logic [RID_W-1:0]   id_q, id_d;
   logic               pass_q, pass_d;
   logic [3:0]         dest_q, dest_d;
   logic [RID_W-1:0]   rid_q, rid_d;
   logic [CNT_W-1:0]   viol_q, viol_d;
   logic [N_DESTS-1:0] ent_vld_q, ent_vld_d;
   logic [3:0]         ent_allow_q [N_DESTS];
   logic [3:0]         ent_allow_d [N_DESTS];

   logic               gnt_found;
   logic [RID_W-1:0]   gnt_idx;
   logic [13:0]        gnt_route;
   logic               e_vld;
   logic [3:0]         e_allow;
   logic               chk_pass;
   logic               unused_bits;

   // Round-robin search starting at rr_ptr_q.
   always_comb begin : p_gnt
      int k;
      k         = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         k = (int'(rr_ptr_q) + i) % N_REQ;
         if (!gnt_found && rbus.req_valid[k]) begin
            gnt_found = 1'b1;
            gnt_idx   = RID_W'(k);
         end
      end
   end

   assign gnt_route   = rbus.req_route[14*int'(gnt_idx) +: 14];
   assign unused_bits = ^{gnt_route[5:0], cfg_route_ctrl[13:10],
                          cfg_route_ctrl[5:0]};

   // Out-of-range dests match no entry and therefore fail.
   always_comb begin
      e_vld   = 1'b0;
      e_allow = '0;
      for (int j = 0; j < N_DESTS; j++) begin
         if (route_q[7:4] == 4'(j)) begin
            e_vld   = ent_vld_q[j];
            e_allow = ent_allow_q[j];
         end
      end
      chk_pass = e_vld && (route_q[3:0] == e_allow ||
                           e_allow == 4'd0 ||
                           route_q[3:0] == 4'd0);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         route_q   <= '0;
         id_q      <= '0;
         pass_q    <= 1'b0;
         dest_q    <= '0;
         rid_q     <= '0;
         viol_q    <= '0;
         ent_vld_q <= '0;
         for (int j = 0; j < N_DESTS; j++) ent_allow_q[j] <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         route_q   <= route_d;
         id_q      <= id_d;
         pass_q    <= pass_d;
         dest_q    <= dest_d;
         rid_q     <= rid_d;
         viol_q    <= viol_d;
         ent_vld_q <= ent_vld_d;
         for (int j = 0; j < N_DESTS; j++) ent_allow_q[j] <= ent_allow_d[j];
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      route_d   = route_q;
      id_d      = id_q;
      pass_d    = pass_q;
      dest_d    = dest_q;
      rid_d     = rid_q;
      viol_d    = viol_q;
      ent_vld_d = ent_vld_q;
      for (int j = 0; j < N_DESTS; j++) ent_allow_d[j] = ent_allow_q[j];

      // Table writes land at the clock edge, so a CHECK in the
      // same cycle still sees the old entry.
      for (int j = 0; j < N_DESTS; j++) begin
         if (cfg_we && cfg_idx == IDX_W'(j)) begin
            ent_vld_d[j]   = 1'b1;
            ent_allow_d[j] = cfg_route_ctrl[9:6];
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               state_d  = S_CHECK;
               route_d  = gnt_route[13:6];
               id_d     = gnt_idx;
               rr_ptr_d = (gnt_idx == RID_W'(N_REQ-1)) ? '0
                                                      : gnt_idx + 1'b1;
            end
         end
         S_CHECK: begin
            state_d = S_RESP;
            pass_d  = chk_pass;
            dest_d  = route_q[7:4];
            rid_d   = id_q;
            if (!chk_pass && viol_q != '1) viol_d = viol_q + 1'b1;
         end
         S_RESP: begin
            if (rbus.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rbus.req_ready = '0;
      if (state_q == S_IDLE && gnt_found) rbus.req_ready[gnt_idx] = 1'b1;
      rbus.rsp_valid  = (state_q == S_RESP);
      rbus.rsp_req_id = rid_q;
      rbus.rsp_pass   = pass_q;
      rbus.rsp_dest   = dest_q;
      busy            = (state_q != S_IDLE);
      viol_cnt        = viol_q;
   end

endmodule

// File: doc/route_check_arbiter.md
ROUTE_CHECK_ARBITER -- requirements
Module: route_check_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the route checker (2..8).
REQ-002 Parameter N_DESTS, default 4, number of destination capability entries (1..16).
REQ-003 Parameter CNT_W, default 16, violation counter width.
REQ-004 One clock; reset is synchronous and active-high. Port aclk input 1: clock; all logic on rising edge.
REQ-005 Port areset input 1: synchronous active-high reset.
REQ-006 Port cfg_we input 1: write one capability entry this cycle.
REQ-007 Port cfg_idx input $clog2(N_DESTS) (min 1): entry index to write.
REQ-008 Port cfg_route_ctrl input 14: capability word; bits [9:6] = allowed sender_id.
REQ-009 Port req_valid input N_REQ: per-requester route-check request.
REQ-010 Port req_route input N_REQ*14: requester i route in bits [14*i+13:14*i]; [13:10] = dest, [9:6] = sender_id.
REQ-011 Port req_ready output N_REQ: one-hot acceptance strobe.
REQ-012 Port rsp_valid output 1, rsp_ready input 1: result handshake.
REQ-013 Port rsp_req_id output $clog2(N_REQ): requester served; rsp_pass output 1; rsp_dest output 4: dest field of checked route.
REQ-014 Port viol_cnt output CNT_W: count of failed checks; busy output 1: FSM not IDLE.

Function
REQ-015 FSM states IDLE, CHECK, RESP; one request in flight at a time.
REQ-016 IDLE: if any req_valid, grant one requester round-robin, assert its req_ready for exactly that cycle, capture its route and id, go CHECK; else stay IDLE with req_ready all zero.
REQ-017 Round-robin: search starts at rr_ptr, wraps N_REQ-1 -> 0; after grant rr_ptr = granted+1 modulo N_REQ; rr_ptr reset value 0.
REQ-018 req_ready is zero in CHECK and RESP; requester i must hold req_valid and req_route stable until req_ready[i].
REQ-019 CHECK (one cycle): compute pass, register rsp_pass/rsp_dest/rsp_req_id, go RESP.
REQ-020 pass = dest < N_DESTS AND entry[dest].valid AND (sender == allowed OR allowed == 0 OR sender == 0).
REQ-021 Fail (pass=0) increments viol_cnt by 1 in the CHECK cycle; viol_cnt saturates at all-ones, never wraps.
REQ-022 RESP: rsp_valid=1, outputs held stable; on rsp_valid&&rsp_ready go IDLE; no grant in that same cycle.
REQ-023 Latency: request accepted cycle T -> rsp_valid first high cycle T+2; minimum spacing between grants 3 cycles.
REQ-024 Config write: entry[cfg_idx] <= {valid=1, allowed=cfg_route_ctrl[9:6]}; takes effect the next cycle; cfg_idx >= N_DESTS ignored.
REQ-025 Config write in same cycle as CHECK of same entry: CHECK uses the pre-write value.
REQ-026 Config writes accepted in every state; they never stall the FSM.
REQ-027 busy = 1 in CHECK and RESP, 0 in IDLE.

Reset
REQ-028 areset high: FSM IDLE, rr_ptr 0, all entries valid=0 allowed=0, viol_cnt 0, rsp_valid 0, rsp_pass 0, rsp_dest 0, rsp_req_id 0, req_ready 0, busy 0.
REQ-029 areset mid-operation discards the in-flight request without response or count update; that requester must re-request.

Verification
REQ-030 Write entry 2 allowed=5; requester 1 route dest=2 sender=5 at T -> req_ready[1] at T, rsp_valid at T+2 with pass=1, dest=2, id=1; viol_cnt 0.
REQ-031 Same entry, sender=3 -> pass=0, viol_cnt 1; sender=0 -> pass=1; entry allowed=0 with sender=7 -> pass=1.
REQ-032 Requests to unwritten entry 3 and to dest=9 (N_DESTS=4) -> both pass=0, viol_cnt +2.
REQ-033 All 4 requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0 spaced 3 cycles; rsp_ready held low 5 cycles -> outputs stable, no new grant.
REQ-034 Preload viol_cnt to all-ones via repeated failures (CNT_W=4: 16 fails) -> stays 15 on further fails.
REQ-035 Assert areset in RESP -> next cycle rsp_valid 0, busy 0, viol_cnt 0, all entries invalid; then any request -> pass=0.
